// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// Each grant lasts up to BURST beats; FIFO full stalls the owner without releasing it.
module fifo_wr_arbiter #(
  parameter int WIDTH = 1,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]      o_wdata,
  output logic                  o_wen,
  input  logic                  i_full,
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;
  logic            r_busy;

  logic            w_any;
  logic [IW-1:0]   w_pick;
  logic            w_owner_valid;
  logic            w_beat;
  logic            w_last;
  logic [IW-1:0]   w_next_ptr;

  // Scan downward over offsets so the smallest offset from the pointer wins.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    idx    = 0;
    w_any  = 1'b0;
    w_pick = r_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(r_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (i_req_valid[idx]) begin
        w_any  = 1'b1;
        w_pick = IW'(idx);
      end
    end
  end

  assign w_owner_valid = i_req_valid[r_owner];
  assign w_beat        = (r_state == GRANT) & w_owner_valid & ~i_full;
  assign w_last        = (r_cnt == CW'(BURST - 1));
  assign w_next_ptr    = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  // Write port is combinational; reset blanks it even mid-burst.
  always_comb begin
    o_req_ready = '0;
    if (r_state == GRANT && !i_full && !i_rst) o_req_ready[r_owner] = 1'b1;
  end

  assign o_wen   = w_beat & ~i_rst;
  assign o_wdata = (r_state == GRANT) ? i_req_data[r_owner*WIDTH +: WIDTH] : '0;
  assign o_grant = r_grant;
  assign o_busy  = r_busy;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_owner <= w_pick;
            r_cnt   <= '0;
            r_grant <= NREQ'(1) << w_pick;
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          // Dropping valid forfeits the rest of the burst; full alone never releases.
          if (!w_owner_valid || (w_beat && w_last)) begin
            r_state <= IDLE;
            r_ptr   <= w_next_ptr;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter (NREQ=3 exercises the non-power-of-two wrap).
// A transaction-level source/arbiter model predicts each cycle; a monitor compares.
module tb_fifo_wr_arbiter;

  localparam int W = 8;
  localparam int N = 3;
  localparam int B = 3;

  logic             clk;
  logic             i_rst;
  logic [N-1:0]     i_req_valid;
  logic [N*W-1:0]   i_req_data;
  logic [N-1:0]     o_req_ready;
  logic [W-1:0]     o_wdata;
  logic             o_wen;
  logic             i_full;
  logic [N-1:0]     o_grant;
  logic             o_busy;

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_wdata     (o_wdata),
    .o_wen       (o_wen),
    .i_full      (i_full),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         busy;
    logic [N-1:0] grant;
    logic [N-1:0] ready;
    logic         wen;
  } cyc_t;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [W-1:0] data;
  } wr_t;

  cyc_t exp_cyc_q [$];
  wr_t  exp_wr_q  [$];

  logic [W-1:0] src_q [N][$];
  logic [N-1:0] v;
  logic         full;

  int m_owner;   // -1 when no requester holds the port
  int m_ptr;
  int m_beats;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and predict the DUT's response to it.
  task automatic step(input logic rst);
    cyc_t e;
    wr_t  w;
    int   k;
    for (int j = 0; j < N; j++) if (src_q[j].size() == 0) v[j] = 1'b0;
    i_rst       = rst;
    i_full      = full;
    i_req_valid = v;
    for (int j = 0; j < N; j++)
      i_req_data[j*W +: W] = (src_q[j].size() > 0) ? src_q[j][0] : '0;

    e = '0;
    e.busy = (m_owner >= 0);
    if (m_owner >= 0) e.grant[m_owner] = 1'b1;

    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (v[k] && m_owner < 0) begin
          m_owner = k;
          m_beats = 0;
        end
      end
    end else begin
      k = m_owner;
      if (!full) e.ready[k] = 1'b1;
      e.wen = v[k] && !full;
      if (e.wen) begin
        w.grant = e.grant;
        w.data  = src_q[k].pop_front();
        exp_wr_q.push_back(w);
        m_beats++;
      end
      if (!v[k] || m_beats == B) begin
        m_owner = -1;
        m_ptr   = (k + 1) % N;
      end
    end
    exp_cyc_q.push_back(e);
  endtask

  task automatic cyc(input logic rst);
    @(negedge clk);
    step(rst);
  endtask

  task automatic fill(input int k, input int cnt);
    for (int i = 0; i < cnt; i++) src_q[k].push_back(W'($urandom));
  endtask

  task automatic all_valid();
    for (int j = 0; j < N; j++) v[j] = (src_q[j].size() > 0);
  endtask

  // Monitor: compares every cycle, and pops a write whenever the DUT writes.
  initial begin
    cyc_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      #2;
      if (exp_cyc_q.size() > 0) begin
        e = exp_cyc_q.pop_front();
        check("busy",  64'(o_busy),      64'(e.busy));
        check("grant", 64'(o_grant),     64'(e.grant));
        check("ready", 64'(o_req_ready), 64'(e.ready));
        check("wen",   64'(o_wen),       64'(e.wen));
      end
      if (o_wen === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write @%0t: got data 0x%0h, expected no write", $time, o_wdata);
        end else begin
          w = exp_wr_q.pop_front();
          check("wdata",    64'(o_wdata), 64'(w.data));
          check("wr_owner", 64'(o_grant), 64'(w.grant));
        end
      end
    end
  end

  initial begin
    i_rst       = 1'b1;
    i_full      = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    v           = '0;
    full        = 1'b0;
    m_owner     = -1;
    m_ptr       = 0;
    m_beats     = 0;

    // Reset, then a quiet bus.
    cyc(1'b1);
    cyc(1'b1);
    for (int c = 0; c < 10; c++) cyc(1'b0);

    // Single requester streams 10 words in bursts separated by one idle cycle.
    fill(2, 10);
    for (int c = 0; c < 16; c++) begin
      all_valid();
      cyc(1'b0);
    end

    // All requesters continuously valid: rotation with wrap.
    for (int j = 0; j < N; j++) fill(j, 6);
    for (int c = 0; c < 30; c++) begin
      all_valid();
      cyc(1'b0);
    end

    // Requester 1 stalled by full for 5 cycles mid-burst.
    fill(1, 6);
    for (int c = 0; c < 20; c++) begin
      all_valid();
      full = (c >= 3 && c < 8);
      cyc(1'b0);
    end
    full = 1'b0;

    // Requester 0 drops valid after one beat; requester 2 gets the next grant.
    cyc(1'b1);
    fill(0, 4);
    fill(2, 2);
    for (int c = 0; c < 16; c++) begin
      v[0] = (c < 2 || c >= 3) && (src_q[0].size() > 0);
      v[1] = 1'b0;
      v[2] = (c >= 2) && (src_q[2].size() > 0);
      cyc(1'b0);
    end

    // Reset pulsed while requester 1 owns the port.
    v = '0;
    cyc(1'b0);
    cyc(1'b0);
    fill(1, 5);
    v[1] = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    for (int c = 0; c < 8; c++) begin
      all_valid();
      cyc(1'b0);
    end

    // Random traffic with backpressure, forfeits and occasional resets.
    for (int c = 0; c < 600; c++) begin
      full = ($urandom_range(0, 4) == 0);
      for (int j = 0; j < N; j++) begin
        if (src_q[j].size() == 0 && $urandom_range(0, 7) == 0) fill(j, $urandom_range(1, 6));
        if (v[j]) begin
          if ($urandom_range(0, 39) == 0) v[j] = 1'b0;
        end else if (src_q[j].size() > 0 && $urandom_range(0, 2) == 0) begin
          v[j] = 1'b1;
        end
      end
      cyc($urandom_range(0, 149) == 0);
    end

    // Drain everything still queued.
    full = 1'b0;
    for (int c = 0; c < 200; c++) begin
      all_valid();
      cyc(1'b0);
    end
    v = '0;
    for (int c = 0; c < 4; c++) cyc(1'b0);

    @(negedge clk);
    #5;
    check("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
    for (int j = 0; j < N; j++) check("src_drained", 64'(src_q[j].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
